dcm_prog_ctrl: RTL and testbench

Upstream configuration stage for the `dcm` clock divider. It turns two raw push-buttons (up/down) into the 3-bit divider program code and a one-cycle `update` strobe. Both outputs drive the divider's `prog_in` and `update` inputs directly. It synchronizes and debounces each button, detects presses, and saturates the code at 0 and 7. A small FSM delays the `update` strobe by one cycle after the code changes, so the divider has already registered the new code when its counter restarts.

---
 rtl/dcm_prog_ctrl.sv | 116 +++++++++++
 tb/tb_dcm_prog_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/dcm_prog_ctrl.sv
// dcm_prog_ctrl: push-button front end for the dcm divider.
// Debounces up/down buttons and emits a 3-bit code plus update strobe.
module dcm_prog_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 4,
    parameter logic [2:0] PROG_RESET      = 3'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [2:0] prog,
    output logic       update,
    output logic       busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PULSE
    } state_t;

    // bit 0 = up, bit 1 = down
    logic [1:0]    btn;
    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    stable;
    logic [1:0]    stable_q;
    logic [1:0]    rise;
    logic [CW-1:0] cnt [2];

    state_t     state;
    state_t     state_next;
    logic [2:0] prog_next;

    assign btn = {btn_down, btn_up};

    // Two-flop synchronizer for the raw asynchronous buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    // Accept a new level only after it persists DEBOUNCE_CYCLES clocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    stable[i] <= s2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Delayed copy of the debounced level for press edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_q <= '0;
        end else begin
            stable_q <= stable;
        end
    end

    assign rise = stable & ~stable_q;

    // State and program code registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            prog  <= PROG_RESET;
        end else begin
            state <= state_next;
            prog  <= prog_next;
        end
    end

    // Next-state logic: one saturating step per accepted press
    always_comb begin
        state_next = state;
        prog_next  = prog;
        unique case (state)
            IDLE: begin
                if (rise == 2'b01 && prog != 3'd7) begin
                    prog_next  = prog + 3'd1;
                    state_next = SETTLE;
                end else if (rise == 2'b10 && prog != 3'd0) begin
                    prog_next  = prog - 3'd1;
                    state_next = SETTLE;
                end
            end
            SETTLE:  state_next = PULSE;
            PULSE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign update = (state == PULSE);
    assign busy   = (state != IDLE);

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// tb_dcm_prog_ctrl: directed self-checking bench for dcm_prog_ctrl.
// Covers reset, press timing, debounce, saturation and overlap cases.
module tb_dcm_prog_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [2:0] prog;
    logic       update;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;
    int upd_n = 0;
    int upd_base;

    dcm_prog_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .PROG_RESET(3'd1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .prog(prog),
        .update(update),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // One count per high cycle of the strobe
    always @(negedge clk) begin
        if (update) upd_n++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        rst      = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input logic up, input logic dn, input int hold);
        @(negedge clk);
        btn_up   = up;
        btn_down = dn;
        repeat (hold) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        // Power-on reset
        rst = 1'b1;
        #2;
        check("por_prog", prog, 1);
        check("por_update", update, 0);
        check("por_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("por_exit_upd", upd_n, 0);

        // Single up press held 10 clocks, edge-exact timing
        upd_base = upd_n;
        @(negedge clk);
        btn_up = 1'b1;
        repeat (6) tick();
        check("up_e6_prog", prog, 1);
        check("up_e6_busy", busy, 0);
        tick();
        check("up_e7_prog", prog, 2);
        check("up_e7_busy", busy, 1);
        check("up_e7_upd", update, 0);
        tick();
        check("up_e8_upd", update, 1);
        check("up_e8_busy", busy, 1);
        tick();
        check("up_e9_upd", update, 0);
        check("up_e9_busy", busy, 0);
        @(posedge clk);
        @(negedge clk);
        btn_up = 1'b0;
        repeat (12) @(negedge clk);
        check("up_hold_prog", prog, 2);
        check("up_hold_events", upd_n - upd_base, 1);

        // Asynchronous reset mid-cycle with prog != reset value
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_prog", prog, 1);
        check("arst_update", update, 0);
        check("arst_busy", busy, 0);
        upd_base = upd_n;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("arst_exit_upd", upd_n - upd_base, 0);

        // Three-clock glitch is rejected
        upd_base = upd_n;
        press(1'b1, 1'b0, 3);
        check("glitch_prog", prog, 1);
        check("glitch_upd", upd_n - upd_base, 0);
        check("glitch_busy", busy, 0);

        // Saturation at 7
        for (int k = 1; k <= 8; k++) begin
            upd_base = upd_n;
            press(1'b1, 1'b0, 6);
            check($sformatf("sat_up%0d_prog", k), prog, (k < 6) ? 1 + k : 7);
            check($sformatf("sat_up%0d_upd", k), upd_n - upd_base,
                  (k <= 6) ? 1 : 0);
        end

        // Saturation at 0
        for (int k = 1; k <= 8; k++) begin
            upd_base = upd_n;
            press(1'b0, 1'b1, 6);
            check($sformatf("sat_dn%0d_prog", k), prog, (k < 7) ? 7 - k : 0);
            check($sformatf("sat_dn%0d_upd", k), upd_n - upd_base,
                  (k <= 7) ? 1 : 0);
        end

        // Both buttons on the same edge
        do_reset();
        upd_base = upd_n;
        press(1'b1, 1'b1, 8);
        check("both_prog", prog, 1);
        check("both_upd", upd_n - upd_base, 0);

        // Down rise lands in PULSE of an up change
        upd_base = upd_n;
        @(negedge clk);
        btn_up = 1'b1;
        repeat (2) @(negedge clk);
        btn_down = 1'b1;
        repeat (10) @(negedge clk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        repeat (14) @(negedge clk);
        check("ovl_prog", prog, 2);
        check("ovl_upd", upd_n - upd_base, 1);

        // Reset while in SETTLE
        do_reset();
        upd_base = upd_n;
        @(negedge clk);
        btn_up = 1'b1;
        repeat (7) tick();
        check("settle_busy", busy, 1);
        check("settle_prog", prog, 2);
        #2;
        rst    = 1'b1;
        btn_up = 1'b0;
        #1;
        check("settle_rst_prog", prog, 1);
        check("settle_rst_busy", busy, 0);
        check("settle_rst_upd", update, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("settle_exit_upd", upd_n - upd_base, 0);
        check("settle_exit_prog", prog, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
